// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor: turns sampled SCL/SDA activity into registered START/Sr/STOP and frame events.
// Define I2C_MON_FILTER_EN to insert a FILTER_LEN-sample glitch filter after the synchronizers.
module i2c_bus_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       start_det,
    output logic       rstart_det,
    output logic       stop_det,
    output logic       bus_busy,
    output logic       frame_valid,
    output logic [7:0] frame_data,
    output logic       frame_ack,
    output logic       frame_is_addr,
    output logic       frame_rw,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

    if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_check
        $error("i2c_bus_monitor: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
    end

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_f;
    logic                   sda_f;
    logic                   scl_p;
    logic                   sda_p;

    // NOTE: the line flops reset to 1, the idle bus level, so reset release never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

`ifdef I2C_MON_FILTER_EN
    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [CNT_W-1:0] scl_cnt;
    logic [CNT_W-1:0] sda_cnt;

    // A level is accepted only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_f   <= 1'b1;
            scl_cnt <= '0;
        end else if (scl_s == scl_f) begin
            scl_cnt <= '0;
        end else if (scl_cnt == CNT_LAST) begin
            scl_f   <= scl_s;
            scl_cnt <= '0;
        end else begin
            scl_cnt <= scl_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_f   <= 1'b1;
            sda_cnt <= '0;
        end else if (sda_s == sda_f) begin
            sda_cnt <= '0;
        end else if (sda_cnt == CNT_LAST) begin
            sda_f   <= sda_s;
            sda_cnt <= '0;
        end else begin
            sda_cnt <= sda_cnt + CNT_W'(1);
        end
    end
`else
    assign scl_f = scl_s;
    assign sda_f = sda_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_p <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_p <= scl_f;
            sda_p <= sda_f;
        end
    end

    // START/STOP need SCL high in both cycles, so SDA moving with an SCL edge is a data bit.
    logic scl_rise;
    logic start_cond;
    logic stop_cond;

    assign scl_rise   = scl_f & ~scl_p;
    assign start_cond = sda_p & ~sda_f & scl_p & scl_f;
    assign stop_cond  = ~sda_p & sda_f & scl_p & scl_f;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] bit_cnt_q;
    logic [3:0] bit_cnt_d;
    logic [7:0] shift_q;
    logic [7:0] shift_d;
    logic       start_det_d;
    logic       rstart_det_d;
    logic       stop_det_d;
    logic       bus_busy_d;
    logic       frame_valid_d;
    logic [7:0] frame_data_d;
    logic       frame_ack_d;
    logic       frame_is_addr_d;
    logic       frame_rw_d;
    logic       frame_err_d;
    logic       mid_frame;

    assign mid_frame = (bit_cnt_q != 4'd0);

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        start_det_d     = 1'b0;
        rstart_det_d    = 1'b0;
        stop_det_d      = 1'b0;
        bus_busy_d      = bus_busy;
        frame_valid_d   = 1'b0;
        frame_data_d    = frame_data;
        frame_ack_d     = frame_ack;
        frame_is_addr_d = frame_is_addr;
        frame_rw_d      = frame_rw;
        frame_err_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_cond) begin
                    state_d     = ST_ADDR;
                    bit_cnt_d   = 4'd0;
                    start_det_d = 1'b1;
                    bus_busy_d  = 1'b1;
                end else if (stop_cond) begin
                    stop_det_d = 1'b1;
                end
            end

            ST_ADDR, ST_DATA: begin
                if (start_cond) begin
                    state_d      = ST_ADDR;
                    bit_cnt_d    = 4'd0;
                    rstart_det_d = 1'b1;
                    frame_err_d  = mid_frame;
                end else if (stop_cond) begin
                    state_d     = ST_IDLE;
                    bit_cnt_d   = 4'd0;
                    stop_det_d  = 1'b1;
                    bus_busy_d  = 1'b0;
                    frame_err_d = mid_frame;
                end else if (scl_rise) begin
                    if (bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else begin
                        frame_valid_d   = 1'b1;
                        frame_data_d    = shift_q;
                        frame_ack_d     = sda_f;
                        frame_is_addr_d = (state_q == ST_ADDR);
                        if (state_q == ST_ADDR) begin
                            frame_rw_d = shift_q[0];
                        end
                        bit_cnt_d = 4'd0;
                        state_d   = ST_DATA;
                    end
                end
            end

            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 4'd0;
            shift_q       <= 8'h00;
            start_det     <= 1'b0;
            rstart_det    <= 1'b0;
            stop_det      <= 1'b0;
            bus_busy      <= 1'b0;
            frame_valid   <= 1'b0;
            frame_data    <= 8'h00;
            frame_ack     <= 1'b1;
            frame_is_addr <= 1'b0;
            frame_rw      <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            start_det     <= start_det_d;
            rstart_det    <= rstart_det_d;
            stop_det      <= stop_det_d;
            bus_busy      <= bus_busy_d;
            frame_valid   <= frame_valid_d;
            frame_data    <= frame_data_d;
            frame_ack     <= frame_ack_d;
            frame_is_addr <= frame_is_addr_d;
            frame_rw      <= frame_rw_d;
            frame_err     <= frame_err_d;
        end
    end

endmodule

// File: doc/i2c_bus_monitor.md
# i2c_bus_monitor

Passive, synchronous I2C bus decoder that samples the open-drain `sda`/`scl` nets and turns bus activity into a registered event stream. It reports START, repeated START, STOP, and each completed 9-bit frame (byte plus ACK) with address, direction and error flags. It never drives the bus. It sits directly downstream of the I2C bus interface and feeds scoreboards, protocol checkers and target-side register logic.

## Interface

- `SYNC_STAGES`, 2: synchronizer depth on `scl_i`/`sda_i`; minimum 2.
- `FILTER_LEN`, 3: consecutive stable samples needed to accept a level change. Used only when `I2C_MON_FILTER_EN` is defined.

- `clk` in 1: sampling clock; must be at least 8x the SCL frequency.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `scl_i` in 1: raw SCL, taken from the pulled-up bus net.
- `sda_i` in 1: raw SDA, taken from the pulled-up bus net.
- `start_det` out 1: one-cycle pulse on START from idle.
- `rstart_det` out 1: one-cycle pulse on START while the bus is busy.
- `stop_det` out 1: one-cycle pulse on STOP.
- `bus_busy` out 1: high from START until STOP.
- `frame_valid` out 1: one-cycle pulse when a 9-bit frame completes.
- `frame_data` out 8: received byte, MSB first; holds until the next frame.
- `frame_ack` out 1: 9th bit; 0 = ACK, 1 = NACK.
- `frame_is_addr` out 1: the frame is the first byte after START or Sr.
- `frame_rw` out 1: `frame_data[0]` of the address frame (1 = read); holds through the data frames.
- `frame_err` out 1: one-cycle pulse when START or STOP truncates a frame.

## Operation

- **Sampling.** Synchronizer flops reset to 1, the idle level of the pulled-up bus. This yields `scl_s`/`sda_s`, then the filtered `scl_f`/`sda_f`. Previous-cycle copies `scl_p`/`sda_p` are kept for edge detection.
- **Events.**
  - `scl_rise` = `scl_f & ~scl_p`.
  - START = `sda_p & ~sda_f & scl_p & scl_f`.
  - STOP = `~sda_p & sda_f & scl_p & scl_f`.
  - SDA changing in the same cycle as an SCL edge is not START/STOP.
- **FSM states:** IDLE, ADDR, DATA. A 4-bit counter `bit_cnt` runs 0..8, and an 8-bit shift register holds the byte.
  - IDLE, START → ADDR: `start_det`=1, `bit_cnt`=0, `bus_busy`=1.
  - ADDR/DATA, `scl_rise` with `bit_cnt` < 8: shift in `sda_f`, increment `bit_cnt`.
  - ADDR/DATA, `scl_rise` with `bit_cnt` = 8: latch the ACK and pulse `frame_valid`. `frame_is_addr` = (state==ADDR); `frame_rw` updates only in ADDR. Then `bit_cnt` = 0 and the FSM goes to DATA.
  - ADDR/DATA, START → ADDR: `rstart_det`=1. If `bit_cnt` is 1..8, also pulse `frame_err`. The partial byte is discarded.
  - ADDR/DATA, STOP → IDLE: `stop_det`=1, `bus_busy`=0. Pulse `frame_err` if `bit_cnt` is 1..8.
  - IDLE, STOP: pulse `stop_det`, no error.
  - IDLE, `scl_rise`: ignored.
- START and STOP take priority over `scl_rise` in the same cycle; by construction these cannot coincide.
- **Reset values.** All pulse outputs 0, `bus_busy` 0, `frame_data` 0x00, `frame_ack` 1, `frame_is_addr` 0, `frame_rw` 0. FSM is IDLE, `bit_cnt` 0.
- **Reset mid-transfer.** State is lost. After release the monitor stays in IDLE, and ignores SCL edges, until a new START.

## Timing

- All outputs are registered.
- Latency from a raw input change to the output pulse:
  - macro undefined: `SYNC_STAGES`+1 clocks.
  - macro defined: `SYNC_STAGES`+`FILTER_LEN`+1 clocks.
- Every pulse is exactly one cycle wide. `frame_valid` and `frame_err` never assert in the same cycle.
- `frame_err` coincides with `rstart_det` or `stop_det`.
- `frame_data`, `frame_ack`, `frame_is_addr` and `frame_rw` are stable in the `frame_valid` cycle and hold afterwards.
- Minimum SCL high/low time for correct decoding: `FILTER_LEN`+2 clocks (filter in), or 2 clocks (filter out).

## Configuration

- `I2C_MON_FILTER_EN` defined:
  - Each synchronized line passes through a saturating counter.
  - `scl_f`/`sda_f` change only after `FILTER_LEN` consecutive samples differ from the current filtered value.
  - The counter resets to 0 on any sample matching the filtered value.
  - Pulses shorter than `FILTER_LEN` clocks are suppressed.
- Undefined: `scl_f` = `scl_s` and `sda_f` = `sda_s`; no filter logic is instantiated.

## Test plan

1. **Write.** START, 0xA0, ACK, 0xA5, ACK, STOP → `start_det`, then frame {0xA0, ack 0, is_addr 1, rw 0}, then frame {0xA5, ack 0, is_addr 0}, then `stop_det`; `bus_busy` returns to 0.
2. **Combined read.** START, 0xA0, 0x10, Sr, 0xA1, 0x3C with NACK, STOP → exactly one `rstart_det`; the 0xA1 frame has is_addr 1, rw 1; the 0x3C frame has ack 1 and rw still 1.
3. **Truncated frame.** STOP after 4 data bits → `frame_err` and `stop_det` in the same cycle, no `frame_valid`, FSM in IDLE. Repeat with Sr after 8 bits → `frame_err` with `rstart_det`.
4. **Glitch, filter in.** With `I2C_MON_FILTER_EN` and `FILTER_LEN`=3, a 2-clock low pulse on `scl_i` inside a bit → no extra bit counted; byte 0x5A decoded correctly. Without the macro, the same stimulus yields a shifted byte.
5. **Reset mid-byte.** Assert `rst_n` after 5 bits → all outputs at reset values asynchronously. Resume SCL toggling without a START → no `frame_valid`. Then a full START/0xA0 → decoded normally.
6. **No false START/STOP.** SDA falls in the same clock as SCL rises → no `start_det`/`stop_det`; the bit is sampled as 0.
